// File: rtl/tl_frag_arb_pkg.sv
// Shared TileLink-UL constants and burst-length helpers for the fragmenter arbiter.
package tl_frag_arb_pkg;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET         = 3'd4;
  localparam logic [2:0] ACK         = 3'd0;
  localparam logic [2:0] ACK_DATA    = 3'd1;

  function automatic int unsigned idx_w_of(input int unsigned n);
    return $clog2(n);
  endfunction

  // A-channel beats: only Puts wider than one beat span several beats
  function automatic int unsigned beats_of(input logic [2:0] opcode, input logic [2:0] size,
                                           input int unsigned beat_lg);
    int unsigned sz;
    sz = 32'(size);
    if ((opcode == PUT_FULL || opcode == PUT_PARTIAL) && sz > beat_lg)
      return 32'd1 << (sz - beat_lg);
    return 32'd1;
  endfunction

  // D-channel beats: only AccessAckData carries a multi-beat payload
  function automatic int unsigned d_beats_of(input logic [2:0] opcode, input logic [2:0] size,
                                             input int unsigned beat_lg);
    int unsigned sz;
    sz = 32'(size);
    if (opcode == ACK_DATA && sz > beat_lg)
      return 32'd1 << (sz - beat_lg);
    return 32'd1;
  endfunction

endpackage

// File: rtl/tl_frag_arbiter_if.sv
// Client-side (packed per client) and fragmenter-side TileLink-UL A/D signals.
interface tl_frag_arbiter_if #(
  parameter int unsigned NUM_CLIENTS  = 2,
  parameter int unsigned CLIENT_SRC_W = 4,
  parameter int unsigned ADDR_W       = 28,
  parameter int unsigned DATA_W       = 32
);
  localparam int unsigned IDX_W      = $clog2(NUM_CLIENTS);
  localparam int unsigned BEAT_BYTES = DATA_W / 8;
  localparam int unsigned SRC_W      = IDX_W + CLIENT_SRC_W;

  logic [NUM_CLIENTS-1:0]              cl_a_valid;
  logic [NUM_CLIENTS-1:0]              cl_a_ready;
  logic [3*NUM_CLIENTS-1:0]            cl_a_opcode;
  logic [3*NUM_CLIENTS-1:0]            cl_a_param;
  logic [3*NUM_CLIENTS-1:0]            cl_a_size;
  logic [NUM_CLIENTS*CLIENT_SRC_W-1:0] cl_a_source;
  logic [NUM_CLIENTS*ADDR_W-1:0]       cl_a_address;
  logic [NUM_CLIENTS*BEAT_BYTES-1:0]   cl_a_mask;
  logic [NUM_CLIENTS*DATA_W-1:0]       cl_a_data;
  logic [NUM_CLIENTS-1:0]              cl_a_corrupt;
  logic [NUM_CLIENTS-1:0]              cl_d_ready;
  logic [NUM_CLIENTS-1:0]              cl_d_valid;
  logic [2:0]                          cl_d_opcode;
  logic [2:0]                          cl_d_size;
  logic [CLIENT_SRC_W-1:0]             cl_d_source;
  logic [DATA_W-1:0]                   cl_d_data;

  logic                                frag_a_valid;
  logic                                frag_a_ready;
  logic [2:0]                          frag_a_opcode;
  logic [2:0]                          frag_a_param;
  logic [2:0]                          frag_a_size;
  logic [SRC_W-1:0]                    frag_a_source;
  logic [ADDR_W-1:0]                   frag_a_address;
  logic [BEAT_BYTES-1:0]               frag_a_mask;
  logic [DATA_W-1:0]                   frag_a_data;
  logic                                frag_a_corrupt;
  logic                                frag_d_valid;
  logic                                frag_d_ready;
  logic [2:0]                          frag_d_opcode;
  logic [2:0]                          frag_d_size;
  logic [SRC_W-1:0]                    frag_d_source;
  logic [DATA_W-1:0]                   frag_d_data;

  // Arbiter view
  modport slave (
    input  cl_a_valid, cl_a_opcode, cl_a_param, cl_a_size, cl_a_source, cl_a_address,
           cl_a_mask, cl_a_data, cl_a_corrupt, cl_d_ready,
           frag_a_ready, frag_d_valid, frag_d_opcode, frag_d_size, frag_d_source, frag_d_data,
    output cl_a_ready, cl_d_valid, cl_d_opcode, cl_d_size, cl_d_source, cl_d_data,
           frag_a_valid, frag_a_opcode, frag_a_param, frag_a_size, frag_a_source,
           frag_a_address, frag_a_mask, frag_a_data, frag_a_corrupt, frag_d_ready
  );

  // Environment view (clients plus fragmenter)
  modport master (
    output cl_a_valid, cl_a_opcode, cl_a_param, cl_a_size, cl_a_source, cl_a_address,
           cl_a_mask, cl_a_data, cl_a_corrupt, cl_d_ready,
           frag_a_ready, frag_d_valid, frag_d_opcode, frag_d_size, frag_d_source, frag_d_data,
    input  cl_a_ready, cl_d_valid, cl_d_opcode, cl_d_size, cl_d_source, cl_d_data,
           frag_a_valid, frag_a_opcode, frag_a_param, frag_a_size, frag_a_source,
           frag_a_address, frag_a_mask, frag_a_data, frag_a_corrupt, frag_d_ready
  );

endinterface

// File: rtl/tl_frag_arbiter_rr_picker.sv
// Rotating-priority N-way pick: first valid and eligible requester from i_ptr upward.
module tl_rr_picker #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     i_valid,
  input  logic [N-1:0]     i_elig,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_any_c,
  output logic [IDX_W-1:0] o_grant_c
);

  logic [IDX_W-1:0] w_idx;

  // N is a power of two, so the index wraps by truncation
  always_comb begin
    o_any_c   = 1'b0;
    o_grant_c = i_ptr;
    w_idx     = '0;
    for (int k = 0; k < int'(N); k++) begin
      w_idx = i_ptr + IDX_W'(k);
      if (!o_any_c && i_valid[w_idx] && i_elig[w_idx]) begin
        o_any_c   = 1'b1;
        o_grant_c = w_idx;
      end
    end
  end

endmodule

// File: rtl/tl_frag_arbiter.sv
// Round-robin TileLink-UL arbiter sharing one fragmenter port; Put bursts hold the grant.
// Define TL_FRAG_ARB_INFLIGHT_LIMIT_EN to cap outstanding requests per client at MAX_INFLIGHT.
module tl_frag_arbiter
  import tl_frag_arb_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS  = 2,
  parameter int unsigned CLIENT_SRC_W = 4,
  parameter int unsigned ADDR_W       = 28,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input logic              clock,
  input logic              reset,
  tl_frag_arbiter_if.slave bus
);

  localparam int unsigned N          = NUM_CLIENTS;
  localparam int unsigned IDX_W      = idx_w_of(N);
  localparam int unsigned BEAT_BYTES = DATA_W / 8;
  localparam int unsigned BEAT_LG    = $clog2(BEAT_BYTES);
  localparam int unsigned SRC_W      = IDX_W + CLIENT_SRC_W;
  localparam int unsigned BEATS_W    = 8;

  if (N < 2 || (N & (N - 1)) != 0 || MAX_INFLIGHT == 0) begin : g_bad_cfg
    $error("tl_frag_arbiter: NUM_CLIENTS must be a power of two >= 2, MAX_INFLIGHT > 0");
  end

  logic [2:0]              w_op    [N];
  logic [2:0]              w_param [N];
  logic [2:0]              w_size  [N];
  logic [CLIENT_SRC_W-1:0] w_src   [N];
  logic [ADDR_W-1:0]       w_addr  [N];
  logic [BEAT_BYTES-1:0]   w_mask  [N];
  logic [DATA_W-1:0]       w_data  [N];

  for (genvar i = 0; i < int'(N); i++) begin : g_unpack
    assign w_op[i]    = bus.cl_a_opcode[3*i +: 3];
    assign w_param[i] = bus.cl_a_param[3*i +: 3];
    assign w_size[i]  = bus.cl_a_size[3*i +: 3];
    assign w_src[i]   = bus.cl_a_source[CLIENT_SRC_W*i +: CLIENT_SRC_W];
    assign w_addr[i]  = bus.cl_a_address[ADDR_W*i +: ADDR_W];
    assign w_mask[i]  = bus.cl_a_mask[BEAT_BYTES*i +: BEAT_BYTES];
    assign w_data[i]  = bus.cl_a_data[DATA_W*i +: DATA_W];
  end

  logic               r_locked;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [BEATS_W-1:0] r_beats_left;

  logic [N-1:0]       w_elig;
  logic               w_pick_any;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [IDX_W-1:0]   w_sel;
  logic               w_a_valid;
  logic               w_a_fire;
  logic [BEATS_W-1:0] w_beats;
  logic [IDX_W-1:0]   w_d_sel;

  tl_rr_picker #(.N(N), .IDX_W(IDX_W)) u_picker (
    .i_valid   (bus.cl_a_valid),
    .i_elig    (w_elig),
    .i_ptr     (r_rr_ptr),
    .o_any_c   (w_pick_any),
    .o_grant_c (w_pick_idx)
  );

  // A-channel mux: a locked burst follows its owner regardless of that client's valid
  assign w_sel     = r_locked ? r_owner : w_pick_idx;
  assign w_a_valid = r_locked ? bus.cl_a_valid[r_owner] : w_pick_any;
  assign w_a_fire  = w_a_valid & bus.frag_a_ready;
  assign w_beats   = BEATS_W'(beats_of(w_op[w_sel], w_size[w_sel], BEAT_LG));

  assign bus.frag_a_valid   = w_a_valid;
  assign bus.frag_a_opcode  = w_op[w_sel];
  assign bus.frag_a_param   = w_param[w_sel];
  assign bus.frag_a_size    = w_size[w_sel];
  assign bus.frag_a_source  = {w_sel, w_src[w_sel]};
  assign bus.frag_a_address = w_addr[w_sel];
  assign bus.frag_a_mask    = w_mask[w_sel];
  assign bus.frag_a_data    = w_data[w_sel];
  assign bus.frag_a_corrupt = bus.cl_a_corrupt[w_sel];

  always_comb begin
    bus.cl_a_ready        = '0;
    bus.cl_a_ready[w_sel] = bus.frag_a_ready & (r_locked | w_pick_any);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_locked     <= 1'b0;
      r_owner      <= '0;
      r_rr_ptr     <= '0;
      r_beats_left <= '0;
    end else if (w_a_fire) begin
      if (r_locked) begin
        r_beats_left <= r_beats_left - BEATS_W'(1);
        if (r_beats_left == BEATS_W'(1)) begin
          r_locked <= 1'b0;
          r_rr_ptr <= r_owner + IDX_W'(1);
        end
      end else if (w_beats > BEATS_W'(1)) begin
        r_locked     <= 1'b1;
        r_owner      <= w_sel;
        r_beats_left <= w_beats - BEATS_W'(1);
      end else begin
        r_rr_ptr <= w_sel + IDX_W'(1);
      end
    end
  end

  // D-channel routing by the index prefix of the returned source
  assign w_d_sel          = bus.frag_d_source[SRC_W-1 -: IDX_W];
  assign bus.frag_d_ready = bus.cl_d_ready[w_d_sel];
  assign bus.cl_d_opcode  = bus.frag_d_opcode;
  assign bus.cl_d_size    = bus.frag_d_size;
  assign bus.cl_d_source  = bus.frag_d_source[CLIENT_SRC_W-1:0];
  assign bus.cl_d_data    = bus.frag_d_data;

  always_comb begin
    bus.cl_d_valid          = '0;
    bus.cl_d_valid[w_d_sel] = bus.frag_d_valid;
  end

`ifdef TL_FRAG_ARB_INFLIGHT_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT) + 1;

  logic               w_d_fire;
  logic               w_d_last;
  logic [BEATS_W-1:0] w_d_beats;
  logic [BEATS_W-1:0] r_d_left;

  assign w_d_fire  = bus.frag_d_valid & bus.frag_d_ready;
  assign w_d_beats = BEATS_W'(d_beats_of(bus.frag_d_opcode, bus.frag_d_size, BEAT_LG));
  assign w_d_last  = (r_d_left == '0) ? (w_d_beats == BEATS_W'(1)) : (r_d_left == BEATS_W'(1));

  // Responses never interleave on D, so one beat counter covers all clients
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_d_left <= '0;
    else if (w_d_fire)
      r_d_left <= (r_d_left == '0) ? (w_d_beats - BEATS_W'(1)) : (r_d_left - BEATS_W'(1));
  end

  for (genvar i = 0; i < int'(N); i++) begin : g_infl
    logic             w_inc;
    logic             w_dec;
    logic [CNT_W-1:0] r_cnt;

    assign w_inc     = w_a_fire & ~r_locked & (w_sel == IDX_W'(i));
    assign w_dec     = w_d_fire & w_d_last & (w_d_sel == IDX_W'(i));
    assign w_elig[i] = r_cnt < CNT_W'(MAX_INFLIGHT);

    always_ff @(posedge clock or posedge reset) begin
      if (reset)
        r_cnt <= '0;
      else if (w_inc && !w_dec)
        r_cnt <= r_cnt + CNT_W'(1);
      else if (w_dec && !w_inc)
        r_cnt <= r_cnt - CNT_W'(1);
    end
  end
`else
  assign w_elig = '1;
`endif

endmodule

// File: tb/tb_tl_frag_arbiter.sv
// Self-checking bench for tl_frag_arbiter: directed scenarios then random traffic vs a reference model.
module tb_tl_frag_arbiter;
  import tl_frag_arb_pkg::*;

  localparam int unsigned N = 2, CSW = 4, AW = 28, DW = 32, MAXI = 4;
  localparam int unsigned IW = 1, SW = IW + CSW, BB = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tl_frag_arbiter_if #(.NUM_CLIENTS(N), .CLIENT_SRC_W(CSW), .ADDR_W(AW), .DATA_W(DW)) tb_if ();

  tl_frag_arbiter #(
    .NUM_CLIENTS(N), .CLIENT_SRC_W(CSW), .ADDR_W(AW), .DATA_W(DW), .MAX_INFLIGHT(MAXI)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (tb_if.slave)
  );

  // Reference model: owner<0 means no burst in progress
  int m_ptr, m_owner, m_left, m_d_left;
  int m_infl [N];
  int n_checks, n_err;
  int d_op, d_sz, d_src;

  function automatic int a_beats(input int op, input int sz);
    if ((op == 0 || op == 1) && (1 << sz) > int'(BB)) return (1 << sz) / int'(BB);
    return 1;
  endfunction

  function automatic int d_beats(input int op, input int sz);
    if (op == 1 && (1 << sz) > int'(BB)) return (1 << sz) / int'(BB);
    return 1;
  endfunction

  function automatic bit eligible(input int c);
`ifdef TL_FRAG_ARB_INFLIGHT_LIMIT_EN
    return m_infl[c] < int'(MAXI);
`else
    return (c >= 0);
`endif
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_left = 0; m_d_left = 0;
    for (int c = 0; c < int'(N); c++) m_infl[c] = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_a(input int c, input bit v, input int op, input int sz, input int src);
    tb_if.cl_a_valid[c]                = v;
    tb_if.cl_a_opcode[c*3 +: 3]        = 3'(op);
    tb_if.cl_a_param[c*3 +: 3]         = 3'($urandom_range(0, 7));
    tb_if.cl_a_size[c*3 +: 3]          = 3'(sz);
    tb_if.cl_a_source[c*CSW +: CSW]    = 4'(src);
    tb_if.cl_a_address[c*AW +: AW]     = 28'($urandom);
    tb_if.cl_a_mask[c*BB +: BB]        = 4'($urandom);
    tb_if.cl_a_data[c*DW +: DW]        = $urandom;
    tb_if.cl_a_corrupt[c]              = 1'($urandom);
  endtask

  task automatic set_d(input bit v, input int op, input int sz, input int src, input int rdy);
    tb_if.frag_d_valid  = v;
    tb_if.frag_d_opcode = 3'(op);
    tb_if.frag_d_size   = 3'(sz);
    tb_if.frag_d_source = 5'(src);
    tb_if.frag_d_data   = $urandom;
    tb_if.cl_d_ready    = 2'(rdy);
  endtask

  task automatic idle_inputs();
    for (int c = 0; c < int'(N); c++) set_a(c, 1'b0, 4, 0, 0);
    set_d(1'b0, 0, 0, 0, 0);
    tb_if.frag_a_ready = 1'b0;
  endtask

  // One clock: check every output at the falling edge, then advance the model on the rising edge.
  // exp_g >= 0 demands that client be granted; -1 demands no A request; -2 is don't-care.
  task automatic cycle(input int exp_g);
    int g, sel, op, b;
    bit ev, af, df, last;
    logic [N-1:0] er, edv;
    @(negedge clk);
    g = -1;
    if (m_owner >= 0) g = m_owner;
    else for (int k = 0; k < int'(N); k++) begin
      int c;
      c = (m_ptr + k) % int'(N);
      if (g < 0 && tb_if.cl_a_valid[c] && eligible(c)) g = c;
    end
    ev = (m_owner >= 0) ? tb_if.cl_a_valid[m_owner] : (g >= 0);
    chk("a_valid", 64'(tb_if.frag_a_valid), 64'(ev));
    if (exp_g == -1) chk("a_idle", 64'(tb_if.frag_a_valid), 64'(0));
    if (exp_g >= 0) begin
      chk("grant_valid", 64'(tb_if.frag_a_valid), 64'(1));
      chk("grant_idx", 64'(tb_if.frag_a_source[SW-1:CSW]), 64'(exp_g));
    end
    if (ev) begin
      chk("a_source", 64'(tb_if.frag_a_source),
          64'((g << CSW) | int'(tb_if.cl_a_source[g*CSW +: CSW])));
      chk("a_opcode", 64'(tb_if.frag_a_opcode), 64'(tb_if.cl_a_opcode[g*3 +: 3]));
      chk("a_param", 64'(tb_if.frag_a_param), 64'(tb_if.cl_a_param[g*3 +: 3]));
      chk("a_size", 64'(tb_if.frag_a_size), 64'(tb_if.cl_a_size[g*3 +: 3]));
      chk("a_addr", 64'(tb_if.frag_a_address), 64'(tb_if.cl_a_address[g*AW +: AW]));
      chk("a_mask", 64'(tb_if.frag_a_mask), 64'(tb_if.cl_a_mask[g*BB +: BB]));
      chk("a_data", 64'(tb_if.frag_a_data), 64'(tb_if.cl_a_data[g*DW +: DW]));
      chk("a_corrupt", 64'(tb_if.frag_a_corrupt), 64'(tb_if.cl_a_corrupt[g]));
    end
    er = '0;
    if (g >= 0) er[g] = tb_if.frag_a_ready;
    chk("cl_a_ready", 64'(tb_if.cl_a_ready), 64'(er));

    sel = int'(tb_if.frag_d_source) >> CSW;
    edv = '0;
    if (tb_if.frag_d_valid) edv[sel] = 1'b1;
    chk("cl_d_valid", 64'(tb_if.cl_d_valid), 64'(edv));
    chk("frag_d_ready", 64'(tb_if.frag_d_ready), 64'(tb_if.cl_d_ready[sel]));
    chk("cl_d_source", 64'(tb_if.cl_d_source), 64'(int'(tb_if.frag_d_source) % (1 << CSW)));
    chk("cl_d_data", 64'(tb_if.cl_d_data), 64'(tb_if.frag_d_data));
    chk("cl_d_opsize", 64'({tb_if.cl_d_opcode, tb_if.cl_d_size}),
        64'({tb_if.frag_d_opcode, tb_if.frag_d_size}));

    af = ev && tb_if.frag_a_ready;
    df = tb_if.frag_d_valid && tb_if.cl_d_ready[sel];
    if (!rst) begin
      if (af) begin
        if (m_owner >= 0) begin
          m_left--;
          if (m_left == 0) begin m_ptr = (m_owner + 1) % int'(N); m_owner = -1; end
        end else begin
          op = int'(tb_if.cl_a_opcode[g*3 +: 3]);
          b  = a_beats(op, int'(tb_if.cl_a_size[g*3 +: 3]));
          m_infl[g]++;
          if (b > 1) begin m_owner = g; m_left = b - 1; end
          else m_ptr = (g + 1) % int'(N);
        end
      end
      if (df) begin
        if (m_d_left == 0) m_d_left = d_beats(int'(tb_if.frag_d_opcode), int'(tb_if.frag_d_size)) - 1;
        else m_d_left--;
        last = (m_d_left == 0);
        if (last) m_infl[sel]--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    cycle(-1);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_err = 0;
    d_op = 0; d_sz = 0; d_src = 0;
    idle_inputs();
    model_reset();

    // Reset state: nothing requested, nothing returned
    cycle(-1);
    cycle(-1);
    rst = 1'b0;

    // Round robin of single-beat Gets
    pulse_reset();
    set_a(0, 1'b1, 4, 2, 5);
    set_a(1, 1'b1, 4, 2, 3);
    tb_if.frag_a_ready = 1'b1;
    cycle(0);
    #2 chk("src_0x13", 64'(tb_if.frag_a_source), 64'h13);
    cycle(1);
    cycle(0);
    cycle(1);

    // Burst lock: client1 2-beat PutFull holds the port with ready 1,0,1
    pulse_reset();
    set_a(0, 1'b1, 4, 2, 5);
    tb_if.frag_a_ready = 1'b1;
    cycle(0);
    set_a(1, 1'b1, 0, 3, 7);
    cycle(1);
    tb_if.frag_a_ready = 1'b0;
    cycle(1);
    tb_if.frag_a_ready = 1'b1;
    cycle(1);
    set_a(1, 1'b1, 4, 2, 7);
    cycle(0);
    cycle(1);

    // D routing by source prefix
    pulse_reset();
    set_a(1, 1'b1, 4, 2, 10);
    tb_if.frag_a_ready = 1'b1;
    cycle(1);
    idle_inputs();
    set_d(1'b1, 0, 2, 'h1A, 'b01);
    #2;
    chk("d_route_valid", 64'(tb_if.cl_d_valid), 64'b10);
    chk("d_route_src", 64'(tb_if.cl_d_source), 64'hA);
    chk("d_route_blocked", 64'(tb_if.frag_d_ready), 64'(0));
    cycle(-1);
    tb_if.cl_d_ready = 2'b10;
    #2 chk("d_route_fire", 64'(tb_if.frag_d_ready), 64'(1));
    cycle(-1);
    set_d(1'b0, 0, 0, 0, 0);

    // Backpressure: stalled grant stays put, pointer does not move
    pulse_reset();
    set_a(0, 1'b1, 4, 2, 1);
    for (int i = 0; i < 5; i++) cycle(0);
    set_a(1, 1'b1, 4, 2, 2);
    cycle(0);
    tb_if.frag_a_ready = 1'b1;
    cycle(0);
    cycle(1);

    // Reset mid-burst: 4-beat PutFull from client0 cut after two beats
    pulse_reset();
    set_a(0, 1'b1, 4, 2, 3);
    tb_if.frag_a_ready = 1'b1;
    cycle(0);
    set_a(0, 1'b1, 0, 4, 3);
    cycle(0);
    cycle(0);
    set_a(0, 1'b0, 0, 4, 3);
    set_a(1, 1'b1, 4, 2, 4);
    rst = 1'b1;
    model_reset();
    cycle(1);
    rst = 1'b0;
    set_a(0, 1'b1, 4, 2, 3);
    cycle(0);

`ifdef TL_FRAG_ARB_INFLIGHT_LIMIT_EN
    // Outstanding limit: fifth Get from client0 waits for a response
    pulse_reset();
    set_a(0, 1'b1, 4, 2, 5);
    tb_if.frag_a_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle(0);
    cycle(-1);
    set_a(1, 1'b1, 4, 2, 6);
    cycle(1);
    cycle(1);
    set_a(1, 1'b0, 4, 2, 6);
    set_d(1'b1, 1, 2, 'h05, 'b01);
    cycle(-1);
    set_d(1'b0, 0, 0, 0, 0);
    cycle(0);
`endif

    // Random traffic against the model
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < int'(N); c++) begin
        int ops [3] = '{0, 1, 4};
        set_a(c, ($urandom_range(0, 9) < 7), ops[$urandom_range(0, 2)],
              $urandom_range(0, 4), $urandom_range(0, 15));
      end
      tb_if.frag_a_ready = 1'($urandom);
      if (m_d_left == 0) begin
        int cand;
        cand = $urandom_range(0, int'(N) - 1);
`ifdef TL_FRAG_ARB_INFLIGHT_LIMIT_EN
        if (m_infl[cand] == 0) cand = (cand + 1) % int'(N);
        if (m_infl[cand] == 0) cand = -1;
`endif
        if (cand >= 0) begin
          d_op  = $urandom_range(0, 1);
          d_sz  = $urandom_range(0, 4);
          d_src = (cand << CSW) | int'($urandom_range(0, 15));
          set_d(1'($urandom), d_op, d_sz, d_src, $urandom_range(0, 3));
        end else begin
          set_d(1'b0, 0, 0, 0, $urandom_range(0, 3));
        end
      end else begin
        set_d(1'($urandom), d_op, d_sz, d_src, $urandom_range(0, 3));
      end
      cycle(-2);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
